// File: rtl/tetris_input_scheduler.sv
// Collects key pulses and gravity ticks into pending requests and offers them
// one at a time to the game engine over a valid/ready handshake.
module tetris_input_scheduler #(
    parameter int GRAV_BASE = 25_000_000,
    parameter int GRAV_STEP = 2_000_000,
    parameter int GRAV_MIN  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] level,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_rot,
    input  logic       key_down,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic       drop_err
);

    localparam int PMAX = (GRAV_BASE > GRAV_MIN) ? GRAV_BASE : GRAV_MIN;
    localparam int PER0 = (GRAV_BASE < GRAV_MIN) ? GRAV_MIN : GRAV_BASE;
    localparam int CW   = $clog2(PMAX + 1);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [4:0]        pend_q, pend_d;
    logic [1:0]        rr_q, rr_d;
    logic [2:0]        cmd_q, cmd_d;
    logic              drop_err_q, drop_err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     period_q, period_d;
    logic [CW-1:0]     period_calc;
    logic signed [63:0] per_raw;
    logic              accept;
    logic              grav_fire;
    logic [4:0]        req;
    logic [4:0]        clr;
    logic [2:0]        grant;
    logic [1:0]        rr_idx;

    assign accept = (state_q == ISSUE) && cmd_ready;

    // 64-bit signed so a large level*step goes negative instead of wrapping.
    always_comb begin
        per_raw = longint'(GRAV_BASE) - longint'(level) * longint'(GRAV_STEP);
        if (per_raw < longint'(GRAV_MIN))
            period_calc = CW'(GRAV_MIN);
        else
            period_calc = CW'(per_raw);
    end

    always_comb begin
        cnt_d     = cnt_q + CW'(1);
        period_d  = period_q;
        grav_fire = 1'b0;
        if (!enable) begin
            cnt_d    = '0;
            period_d = period_calc;
        end else if (cnt_q == period_q - CW'(1)) begin
            cnt_d     = '0;
            period_d  = period_calc;
            grav_fire = 1'b1;
        end else if (accept && cmd_q == 3'd4) begin
            cnt_d    = '0;
            period_d = period_calc;
        end
    end

    // A request on a bit being cleared this cycle re-arms it rather than dropping.
    always_comb begin
        req = {grav_fire, key_down, key_rot, key_right, key_left} & {5{enable}};
        clr = '0;
        if (accept)
            clr[cmd_q - 3'd1] = 1'b1;
        drop_err_d = drop_err_q | (|(req & pend_q & ~clr));
        pend_d     = enable ? ((pend_q & ~clr) | req) : '0;
    end

    // Gravity wins outright; keys scan from rr_q, lowest offset wins.
    always_comb begin
        grant  = 3'd0;
        rr_idx = rr_q;
        if (pend_q[4]) begin
            grant = 3'd5;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                rr_idx = rr_q + 2'(k);
                if (pend_q[{1'b0, rr_idx}])
                    grant = {1'b0, rr_idx} + 3'd1;
            end
        end
    end

    // Key code c belongs to source c-1, so the next source is c mod 4.
    always_comb begin
        rr_d = rr_q;
        if (accept && cmd_q != 3'd5)
            rr_d = cmd_q[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: begin
                if (enable && (|pend_q)) begin
                    state_d = ISSUE;
                    cmd_d   = grant;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = IDLE;
                    cmd_d   = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cmd_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        cmd_valid = (state_q == ISSUE);
        cmd       = cmd_q;
        drop_err  = drop_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            rr_q       <= 2'd0;
            cmd_q      <= 3'd0;
            drop_err_q <= 1'b0;
            cnt_q      <= '0;
            period_q   <= CW'(PER0);
        end else begin
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            cmd_q      <= cmd_d;
            drop_err_q <= drop_err_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
        end
    end

endmodule

// File: tb/tb_tetris_input_scheduler.sv
// Bench for tetris_input_scheduler: a request-level model checked every cycle,
// plus directed scenarios with hand-computed command order and timing.
module tb_tetris_input_scheduler;

    localparam int GB = 100;
    localparam int GS = 10;
    localparam int GM = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] level = 4'd0;
    logic       key_left = 1'b0, key_right = 1'b0, key_rot = 1'b0, key_down = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       drop_err;

    tetris_input_scheduler #(.GRAV_BASE(GB), .GRAV_STEP(GS), .GRAV_MIN(GM)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .level(level),
        .key_left(key_left), .key_right(key_right), .key_rot(key_rot), .key_down(key_down),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: who is waiting, what is on offer, whose turn, how long since gravity reload.
    typedef struct {
        bit       offer;
        int       cmd;
        bit [4:0] pend;
        int       rr;
        int       elapsed;
        int       period;
        bit       derr;
    } model_t;

    model_t m;

    function automatic int period_of(int lv);
        int p;
        p = GB - lv * GS;
        if (p < GM) p = GM;
        return p;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.offer = 1'b0; r.cmd = 0; r.pend = '0; r.rr = 0;
        r.elapsed = 0; r.period = period_of(0); r.derr = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(model_t cur, bit en, int lv, bit [3:0] keys, bit rdy);
        model_t   n;
        bit       took;
        bit       fire;
        bit [4:0] rq;
        int       src;
        n    = cur;
        took = cur.offer && rdy;
        if (took) begin
            n.pend[cur.cmd-1] = 1'b0;
            if (cur.cmd < 5) n.rr = cur.cmd % 4;
            n.offer = 1'b0;
            n.cmd   = 0;
        end
        fire = en && (cur.elapsed == cur.period - 1);
        if (!en || fire || (took && cur.cmd == 4)) begin
            n.elapsed = 0;
            n.period  = period_of(lv);
        end else begin
            n.elapsed = cur.elapsed + 1;
        end
        rq = {fire, keys};
        for (int s = 0; s < 5; s++) begin
            if (en && rq[s]) begin
                if (n.pend[s]) n.derr = 1'b1;
                n.pend[s] = 1'b1;
            end
        end
        if (!en) n.pend = '0;
        if (!cur.offer && en && cur.pend != 0) begin
            n.offer = 1'b1;
            if (cur.pend[4]) begin
                n.cmd = 5;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    src = (cur.rr + k) % 4;
                    if (cur.pend[src]) begin
                        n.cmd = src + 1;
                        break;
                    end
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m <= model_reset();
        else
            m <= model_step(m, enable, int'(level), {key_down, key_rot, key_right, key_left}, cmd_ready);
    end

    typedef struct { int c; int t; } ev_t;
    ev_t acc_q[$];
    int  tests = 0;
    int  fails = 0;
    int  c0;

    task automatic check(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic compare();
        check("model_cmd_valid", int'(cmd_valid), int'(m.offer));
        check("model_cmd", int'(cmd), m.cmd);
        check("model_drop_err", int'(drop_err), int'(m.derr));
        if (rst_n && cmd_valid && cmd_ready) begin
            ev_t e;
            e.c = int'(cmd);
            e.t = cyc;
            acc_q.push_back(e);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            compare();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(3);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd", int'(cmd), 0);
        check("rst_drop_err", int'(drop_err), 0);
        rst_n = 1'b1;
        tick(2);

        // Free-running gravity, level 0: first issue 101 cycles in, then every 100.
        acc_q.delete(); cmd_ready = 1'b1; level = 4'd0; enable = 1'b1; c0 = cyc;
        tick(310);
        check("l0_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("l0_first_lat", acc_q[0].t - c0, 101);
            check("l0_code", acc_q[0].c, 5);
            check("l0_gap1", acc_q[1].t - acc_q[0].t, 100);
            check("l0_gap2", acc_q[2].t - acc_q[1].t, 100);
        end
        enable = 1'b0; tick(2);

        // Level 9 clamps to 20 cycles.
        level = 4'd9; tick(1);
        acc_q.delete(); enable = 1'b1; c0 = cyc;
        tick(70);
        check("l9_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("l9_first_lat", acc_q[0].t - c0, 21);
            check("l9_gap", acc_q[2].t - acc_q[1].t, 20);
        end

        // Level 3 gives 70 cycles.
        enable = 1'b0; level = 4'd3; tick(2);
        acc_q.delete(); enable = 1'b1; c0 = cyc;
        tick(220);
        check("l3_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("l3_first_lat", acc_q[0].t - c0, 71);
            check("l3_gap", acc_q[1].t - acc_q[0].t, 70);
        end
        enable = 1'b0; level = 4'd0; tick(2);

        // Three simultaneous keys: 1,2,3 with one idle cycle between; then turn sits at DOWN.
        acc_q.delete(); cmd_ready = 1'b1; enable = 1'b1; tick(1);
        key_left = 1'b1; key_right = 1'b1; key_rot = 1'b1; tick(1);
        key_left = 1'b0; key_right = 1'b0; key_rot = 1'b0; tick(10);
        check("rr3_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("rr3_first", acc_q[0].c, 1);
            check("rr3_second", acc_q[1].c, 2);
            check("rr3_third", acc_q[2].c, 3);
            check("rr3_spacing", acc_q[1].t - acc_q[0].t, 2);
        end
        key_left = 1'b1; key_down = 1'b1; tick(1);
        key_left = 1'b0; key_down = 1'b0; tick(8);
        check("rr_down_count", acc_q.size(), 5);
        if (acc_q.size() == 5) begin
            check("rr_down_first", acc_q[3].c, 4);
            check("rr_down_then_left", acc_q[4].c, 1);
        end
        enable = 1'b0; tick(2);

        // Stalled LEFT holds while RIGHT and gravity arrive; gravity jumps ahead of RIGHT.
        acc_q.delete(); cmd_ready = 1'b0; enable = 1'b1; key_left = 1'b1; tick(1);
        key_left = 1'b0; tick(90);
        key_right = 1'b1; tick(1);
        key_right = 1'b0; tick(15);
        check("stall_valid", int'(cmd_valid), 1);
        check("stall_cmd", int'(cmd), 1);
        cmd_ready = 1'b1; tick(8);
        check("stall_count", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            check("stall_order0", acc_q[0].c, 1);
            check("stall_order1", acc_q[1].c, 5);
            check("stall_order2", acc_q[2].c, 2);
        end
        enable = 1'b0; tick(2);

        // A pulse in the acceptance cycle re-arms LEFT without flagging a drop.
        acc_q.delete(); cmd_ready = 1'b0; enable = 1'b1; key_left = 1'b1; tick(1);
        key_left = 1'b0; tick(3);
        cmd_ready = 1'b1; key_left = 1'b1; tick(1);
        cmd_ready = 1'b0; key_left = 1'b0; tick(3);
        check("rearm_valid", int'(cmd_valid), 1);
        check("rearm_cmd", int'(cmd), 1);
        check("rearm_no_drop", int'(drop_err), 0);
        cmd_ready = 1'b1; tick(3);
        check("rearm_count", acc_q.size(), 2);
        enable = 1'b0; tick(2);

        // Keys while disabled are ignored entirely.
        acc_q.delete(); key_left = 1'b1; tick(2);
        key_left = 1'b0; enable = 1'b1; cmd_ready = 1'b1; tick(5);
        check("dis_ignored_count", acc_q.size(), 0);
        check("dis_no_drop", int'(drop_err), 0);

        // Second LEFT three cycles later while the first is still pending is dropped.
        cmd_ready = 1'b0; key_left = 1'b1; tick(1);
        key_left = 1'b0; tick(2);
        key_left = 1'b1; tick(1);
        key_left = 1'b0; tick(1);
        check("drop_flag", int'(drop_err), 1);
        cmd_ready = 1'b1; tick(6);
        check("drop_count", acc_q.size(), 1);
        if (acc_q.size() == 1) check("drop_code", acc_q[0].c, 1);
        enable = 1'b0; tick(2);

        // DOWN accepted at count 60 restarts gravity: GRAV shows up 102 cycles after
        // the DOWN acceptance (same reload-to-issue latency as free-running), not 40.
        acc_q.delete(); cmd_ready = 1'b1; level = 4'd0; enable = 1'b1;
        tick(58);
        key_down = 1'b1; tick(1);
        key_down = 1'b0; tick(160);
        check("soft_count", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            check("soft_down", acc_q[0].c, 4);
            check("soft_grav", acc_q[1].c, 5);
            check("soft_gap", acc_q[1].t - acc_q[0].t, 102);
        end

        // Asynchronous reset in the middle of an offer.
        cmd_ready = 1'b0; key_left = 1'b1; tick(1);
        key_left = 1'b0; tick(3);
        check("pre_rst_valid", int'(cmd_valid), 1);
        check("pre_rst_drop", int'(drop_err), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(cmd_valid), 0);
        check("async_rst_cmd", int'(cmd), 0);
        check("async_rst_drop", int'(drop_err), 0);
        tick(2);
        rst_n = 1'b1; acc_q.delete(); cmd_ready = 1'b1;
        tick(5);
        check("rst_discard", acc_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
